// File: rtl/charge_session_ctrl_if.sv
// Signal bundle between the charge session controller and its environment
// (debounced user inputs, plug sense and Counter_Main).
interface charge_session_ctrl_if;
    logic        CoinIn;
    logic        Start;
    logic        Stop;
    logic        PlugIn;
    logic [11:0] PresentTime;
    logic        CounterEnable;
    logic [3:0]  CounterInput;
    logic        CounterClr_n;
    logic        ChargeOn;
    logic        Done;
    logic [3:0]  Credit;
    logic [2:0]  State;

    modport master (
        output CoinIn, Start, Stop, PlugIn, PresentTime,
        input  CounterEnable, CounterInput, CounterClr_n, ChargeOn, Done, Credit, State
    );

    modport slave (
        input  CoinIn, Start, Stop, PlugIn, PresentTime,
        output CounterEnable, CounterInput, CounterClr_n, ChargeOn, Done, Credit, State
    );
endinterface

// File: rtl/charge_session_ctrl.sv
// Session controller for one charging bay: buys minutes of credit, clears and runs
// Counter_Main, and ends the charge on timeout, stop or unplug.
module charge_session_ctrl #(
    parameter logic [3:0] STEP       = 4'd1,
    parameter logic [3:0] MAX_CREDIT = 4'd9,
    parameter logic [7:0] DONE_HOLD  = 8'd50
) (
    input logic                  Clk,
    input logic                  nReset,
    charge_session_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArmed    = 3'd1,
        StClear    = 3'd2,
        StCharging = 3'd3,
        StPaused   = 3'd4,
        StDone     = 3'd5
    } state_e;

    state_e     stateQ, stateD;
    logic [3:0] creditQ, creditD;
    logic [7:0] holdQ, holdD;
    logic       enableQ, clrNQ, chargeQ, doneQ;
    logic [3:0] inputQ;
    logic [3:0] creditInc;
    logic       timeout;

    // Whole minutes elapsed reached the credit, exactly on the minute boundary.
    assign timeout = (bus.PresentTime[11:8] >= creditQ) && (bus.PresentTime[7:0] == 8'h00) &&
                     (bus.PresentTime[11:8] != 4'd0);

    assign creditInc = (creditQ < MAX_CREDIT) ? creditQ + 4'd1 : creditQ;

    always_comb begin
        stateD  = stateQ;
        creditD = creditQ;
        holdD   = 8'd0;
        unique case (stateQ)
            StIdle: begin
                if (bus.CoinIn) begin
                    stateD  = StArmed;
                    creditD = 4'd1;
                end
            end
            StArmed: begin
                if (bus.Stop) begin
                    stateD  = StIdle;
                    creditD = 4'd0;
                end else if (bus.Start && bus.PlugIn) begin
                    stateD = StClear;
                end else if (bus.CoinIn) begin
                    creditD = creditInc;
                end
            end
            StClear: begin
                stateD = bus.PlugIn ? StCharging : StDone;
            end
            StCharging: begin
                if (!bus.PlugIn || timeout) begin
                    stateD = StDone;
                end else if (bus.Stop) begin
                    stateD = StPaused;
                end else if (bus.CoinIn) begin
                    creditD = creditInc;
                end
            end
            StPaused: begin
                if (!bus.PlugIn || bus.Stop) begin
                    stateD = StDone;
                end else if (bus.Start) begin
                    stateD = StCharging;
                end else if (bus.CoinIn) begin
                    creditD = creditInc;
                end
            end
            StDone: begin
                if (holdQ == DONE_HOLD - 8'd1) begin
                    stateD  = StIdle;
                    creditD = 4'd0;
                end else begin
                    holdD = holdQ + 8'd1;
                end
            end
            default: begin
                stateD  = StIdle;
                creditD = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change with the transition edge.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            stateQ  <= StIdle;
            creditQ <= 4'd0;
            holdQ   <= 8'd0;
            enableQ <= 1'b0;
            clrNQ   <= 1'b1;
            chargeQ <= 1'b0;
            doneQ   <= 1'b0;
            inputQ  <= STEP;
        end else begin
            stateQ  <= stateD;
            creditQ <= creditD;
            holdQ   <= holdD;
            enableQ <= (stateD == StCharging);
            clrNQ   <= (stateD != StClear);
            chargeQ <= (stateD == StCharging);
            doneQ   <= (stateD == StDone);
            inputQ  <= STEP;
        end
    end

    assign bus.CounterEnable = enableQ;
    assign bus.CounterInput  = inputQ;
    assign bus.CounterClr_n  = clrNQ;
    assign bus.ChargeOn      = chargeQ;
    assign bus.Done          = doneQ;
    assign bus.Credit        = creditQ;
    assign bus.State         = stateQ;

endmodule

// File: tb/tb_charge_session_ctrl.sv
// Directed bench for charge_session_ctrl: one task per scenario, each with inline
// checks against hand-computed values.
module tb_charge_session_ctrl;

    logic Clk;
    logic nReset;
    int   passCnt  = 0;
    int   checkCnt = 0;

    charge_session_ctrl_if bus ();

    charge_session_ctrl dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyReset();
        nReset          = 1'b0;
        bus.CoinIn      = 1'b0;
        bus.Start       = 1'b0;
        bus.Stop        = 1'b0;
        bus.PlugIn      = 1'b0;
        bus.PresentTime = 12'h000;
        tick();
        nReset = 1'b1;
    endtask

    task automatic coin();
        bus.CoinIn = 1'b1;
        tick();
        bus.CoinIn = 1'b0;
    endtask

    // From IDLE: buy n minutes, plug in, start, and land in CHARGING.
    task automatic startCharge(input int n);
        for (int i = 0; i < n; i++) coin();
        bus.PlugIn = 1'b1;
        bus.Start  = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        applyReset();
        nReset = 1'b0;
        tick();
        checkCnt++;
        if (bus.State !== 3'd0) $display("FAIL reset_state got=%0d exp=0", bus.State);
        else passCnt++;
        checkCnt++;
        if (bus.Credit !== 4'd0) $display("FAIL reset_credit got=%0d exp=0", bus.Credit);
        else passCnt++;
        checkCnt++;
        if ({bus.CounterEnable, bus.CounterClr_n, bus.ChargeOn, bus.Done} !== 4'b0100)
            $display("FAIL reset_outs got=%b exp=0100",
                     {bus.CounterEnable, bus.CounterClr_n, bus.ChargeOn, bus.Done});
        else passCnt++;
        checkCnt++;
        if (bus.CounterInput !== 4'd1) $display("FAIL reset_step got=%0d exp=1", bus.CounterInput);
        else passCnt++;
        nReset = 1'b1;
    endtask

    task automatic test_full_session();
        applyReset();
        coin();
        checkCnt++;
        if (bus.State !== 3'd1 || bus.Credit !== 4'd1)
            $display("FAIL first_coin got=%0d/%0d exp=1/1", bus.State, bus.Credit);
        else passCnt++;
        coin();
        coin();
        checkCnt++;
        if (bus.Credit !== 4'd3) $display("FAIL three_coins got=%0d exp=3", bus.Credit);
        else passCnt++;
        bus.PlugIn = 1'b1;
        bus.Start  = 1'b1;
        tick();
        bus.Start = 1'b0;
        checkCnt++;
        if (bus.State !== 3'd2 || bus.CounterClr_n !== 1'b0 || bus.CounterEnable !== 1'b0)
            $display("FAIL clear_cycle got=%0d/%b/%b exp=2/0/0",
                     bus.State, bus.CounterClr_n, bus.CounterEnable);
        else passCnt++;
        tick();
        checkCnt++;
        if (bus.State !== 3'd3 || bus.CounterClr_n !== 1'b1 || bus.CounterEnable !== 1'b1 ||
            bus.ChargeOn !== 1'b1)
            $display("FAIL charging_entry got=%0d/%b/%b/%b exp=3/1/1/1", bus.State,
                     bus.CounterClr_n, bus.CounterEnable, bus.ChargeOn);
        else passCnt++;
        bus.PresentTime = 12'h259;
        tick();
        checkCnt++;
        if (bus.State !== 3'd3) $display("FAIL no_early_timeout got=%0d exp=3", bus.State);
        else passCnt++;
        bus.PresentTime = 12'h300;
        tick();
        bus.PresentTime = 12'h000;
        checkCnt++;
        if (bus.State !== 3'd5 || bus.Done !== 1'b1 || bus.CounterEnable !== 1'b0 ||
            bus.ChargeOn !== 1'b0 || bus.Credit !== 4'd3)
            $display("FAIL timeout_done got=%0d/%b/%b/%b/%0d exp=5/1/0/0/3", bus.State,
                     bus.Done, bus.CounterEnable, bus.ChargeOn, bus.Credit);
        else passCnt++;
        for (int i = 0; i < 49; i++) tick();
        checkCnt++;
        if (bus.State !== 3'd5) $display("FAIL done_hold got=%0d exp=5", bus.State);
        else passCnt++;
        tick();
        checkCnt++;
        if (bus.State !== 3'd0 || bus.Credit !== 4'd0 || bus.Done !== 1'b0)
            $display("FAIL done_release got=%0d/%0d/%b exp=0/0/0",
                     bus.State, bus.Credit, bus.Done);
        else passCnt++;
    endtask

    task automatic test_saturation();
        applyReset();
        for (int i = 0; i < 12; i++) coin();
        checkCnt++;
        if (bus.Credit !== 4'd9) $display("FAIL sat_idle got=%0d exp=9", bus.Credit);
        else passCnt++;
        startCharge(0);
        coin();
        checkCnt++;
        if (bus.State !== 3'd3 || bus.Credit !== 4'd9)
            $display("FAIL sat_charging got=%0d/%0d exp=3/9", bus.State, bus.Credit);
        else passCnt++;
    endtask

    task automatic test_pause_resume();
        applyReset();
        startCharge(2);
        checkCnt++;
        if (bus.State !== 3'd3 || bus.Credit !== 4'd2)
            $display("FAIL pause_setup got=%0d/%0d exp=3/2", bus.State, bus.Credit);
        else passCnt++;
        bus.Stop = 1'b1;
        tick();
        bus.Stop = 1'b0;
        checkCnt++;
        if (bus.State !== 3'd4 || bus.CounterEnable !== 1'b0 || bus.ChargeOn !== 1'b0)
            $display("FAIL pause got=%0d/%b/%b exp=4/0/0",
                     bus.State, bus.CounterEnable, bus.ChargeOn);
        else passCnt++;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        checkCnt++;
        if (bus.State !== 3'd3 || bus.CounterClr_n !== 1'b1 || bus.CounterEnable !== 1'b1)
            $display("FAIL resume got=%0d/%b/%b exp=3/1/1",
                     bus.State, bus.CounterClr_n, bus.CounterEnable);
        else passCnt++;
        bus.Stop  = 1'b1;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        checkCnt++;
        if (bus.State !== 3'd4) $display("FAIL stop_beats_start got=%0d exp=4", bus.State);
        else passCnt++;
        tick();
        bus.Stop = 1'b0;
        checkCnt++;
        if (bus.State !== 3'd5 || bus.Done !== 1'b1)
            $display("FAIL paused_stop got=%0d/%b exp=5/1", bus.State, bus.Done);
        else passCnt++;
    endtask

    task automatic test_unplug_priority();
        applyReset();
        startCharge(1);
        bus.PlugIn = 1'b0;
        bus.Stop   = 1'b1;
        tick();
        bus.Stop = 1'b0;
        checkCnt++;
        if (bus.State !== 3'd5 || bus.ChargeOn !== 1'b0)
            $display("FAIL unplug_priority got=%0d/%b exp=5/0", bus.State, bus.ChargeOn);
        else passCnt++;
    endtask

    task automatic test_armed();
        applyReset();
        coin();
        bus.PlugIn = 1'b0;
        bus.Start  = 1'b1;
        tick();
        bus.Start = 1'b0;
        checkCnt++;
        if (bus.State !== 3'd1) $display("FAIL armed_unplugged_start got=%0d exp=1", bus.State);
        else passCnt++;
        bus.Stop = 1'b1;
        tick();
        bus.Stop = 1'b0;
        checkCnt++;
        if (bus.State !== 3'd0 || bus.Credit !== 4'd0)
            $display("FAIL armed_refund got=%0d/%0d exp=0/0", bus.State, bus.Credit);
        else passCnt++;
    endtask

    task automatic test_reset_mid();
        applyReset();
        startCharge(4);
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        checkCnt++;
        if (bus.State !== 3'd0 || bus.Credit !== 4'd0 || bus.CounterEnable !== 1'b0 ||
            bus.CounterClr_n !== 1'b1 || bus.ChargeOn !== 1'b0 || bus.Done !== 1'b0 ||
            bus.CounterInput !== 4'd1)
            $display("FAIL reset_mid got=%0d/%0d/%b/%b/%b/%b/%0d exp=0/0/0/1/0/0/1",
                     bus.State, bus.Credit, bus.CounterEnable, bus.CounterClr_n,
                     bus.ChargeOn, bus.Done, bus.CounterInput);
        else passCnt++;
    endtask

    task automatic test_timeout_coin();
        applyReset();
        startCharge(1);
        bus.PresentTime = 12'h100;
        bus.CoinIn      = 1'b1;
        tick();
        bus.CoinIn      = 1'b0;
        bus.PresentTime = 12'h000;
        checkCnt++;
        if (bus.State !== 3'd5 || bus.Credit !== 4'd1)
            $display("FAIL timeout_with_coin got=%0d/%0d exp=5/1", bus.State, bus.Credit);
        else passCnt++;
    endtask

    initial begin
        test_reset();
        test_full_session();
        test_saturation();
        test_pause_resume();
        test_unplug_priority();
        test_armed();
        test_reset_mid();
        test_timeout_coin();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/charge_session_ctrl.md
Name: charge_session_ctrl

Overview:
Session controller for one charging bay. It accepts coin credit in whole minutes and arms the session, then clears and enables Counter_Main. It watches the counter's BCD M:SS PresentTime and ends the charge when elapsed time reaches the purchased credit. Pause/resume, unplug abort and a timed done indication are included. It sits between the user-input debounce logic and Counter_Main, and drives Counter_Main's enable, step input and clear.

Parameters:
STEP, 4'd1, value driven on CounterInput (counter step per count event)
MAX_CREDIT, 4'd9, credit saturation limit in minutes (BCD digit, 1..9)
DONE_HOLD, 8'd50, clock cycles the DONE state is held before returning to IDLE

Ports:
Clk  in  1  system clock, rising edge
nReset  in  1  synchronous active-low reset
CoinIn  in  1  one-cycle pulse: add one minute of credit
Start  in  1  one-cycle pulse: start or resume charging
Stop  in  1  one-cycle pulse: pause, or end the session when already paused
PlugIn  in  1  level: vehicle connected
PresentTime  in  12  elapsed time from Counter_Main, BCD [11:8]=min, [7:4]=tens s, [3:0]=s
CounterEnable  out  1  enable to Counter_Main
CounterInput  out  4  step value to Counter_Main
CounterClr_n  out  1  active-low one-cycle clear to Counter_Main
ChargeOn  out  1  charger contactor drive
Done  out  1  session finished indication
Credit  out  4  purchased minutes, binary 0..MAX_CREDIT
State  out  3  FSM state code, for debug and display

Behaviour:
- All outputs are registered. Reset: state IDLE, CounterEnable=0, CounterInput=STEP, CounterClr_n=1, ChargeOn=0, Done=0, Credit=0, State=3'd0, hold counter=0.
- A reset asserted mid-session aborts immediately to the reset values. No state survives the reset.
- State codes: IDLE=0, ARMED=1, CLEAR=2, CHARGING=3, PAUSED=4, DONE=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- Outputs change on the clock edge after the causing input is sampled (1-cycle latency).
- Priority within a cycle, highest first: nReset, unplug, timeout, Stop, Start, CoinIn.
- IDLE: CoinIn sets Credit=1 and goes to ARMED. Start, Stop and unplug are ignored.
- ARMED: CoinIn increments Credit, saturating at MAX_CREDIT. Start with PlugIn=1 goes to CLEAR. Start with PlugIn=0 is ignored. Stop clears Credit and returns to IDLE (refund path).
- CLEAR: lasts exactly one cycle. CounterClr_n=0 and CounterEnable=0. Next state is CHARGING unconditionally, unless PlugIn=0, which goes to DONE.
- CHARGING: CounterEnable=1, ChargeOn=1.
  - Timeout: PresentTime[11:8] >= Credit AND PresentTime[7:0]==8'h00 AND PresentTime[11:8]!=0 goes to DONE.
  - Stop goes to PAUSED.
  - PlugIn=0 goes to DONE.
  - CoinIn extends Credit, saturating. A coin in the same cycle as a timeout is discarded.
- PAUSED: CounterEnable=0, ChargeOn=0, PresentTime is held by the counter. Start resumes to CHARGING with no clear. Stop goes to DONE. PlugIn=0 goes to DONE. CoinIn is accepted, saturating.
- Start and Stop in the same cycle: Stop wins.
- DONE: Done=1, CounterEnable=0, ChargeOn=0. Credit is held for display. The hold counter counts DONE_HOLD cycles, then Credit clears to 0 and the FSM returns to IDLE. All inputs are ignored in DONE.
- CounterEnable and ChargeOn fall on the same edge as the transition out of CHARGING. There is no overlap cycle.
- Credit arithmetic is 4-bit. It never exceeds MAX_CREDIT and never wraps.

Test Plan:
- Reset, then 3 CoinIn pulses, PlugIn=1, Start -> Credit=3. State 1 -> 2 (CounterClr_n=0 for exactly 1 cycle) -> 3. Drive PresentTime=12'h259: stays CHARGING. Drive 12'h300: next edge Done=1, CounterEnable=0, ChargeOn=0, State=5. After 50 cycles State=0, Credit=0.
- 12 CoinIn pulses from IDLE -> Credit saturates at 9. A further coin in CHARGING -> Credit stays 9.
- CHARGING at Credit=2, Stop -> State=4, CounterEnable=0. Start -> State=3 with no CounterClr_n pulse. Stop and Start in the same cycle while CHARGING -> State=4.
- CHARGING, PlugIn dropped to 0 together with Stop -> State=5 on the next edge (unplug priority).
- ARMED, Start with PlugIn=0 -> remains State=1. Stop -> State=0, Credit=0.
- nReset=0 mid-CHARGING for 1 cycle -> all outputs at reset values on that edge. Timeout and CoinIn in the same cycle with Credit=1, PresentTime=12'h100 -> DONE, Credit=1.
